mips_run_monitor: RTL and testbench
===================================

Name: mips_run_monitor

Overview:
- Parametrised, reusable end-of-program checker for the mips_cpu_harvard test benches.
- Replaces hand-written per-test halt/assert blocks.
- Watches the CPU instruction fetch address for the halt address and counts cycles.
- On halt, compares register_v0 to an expected value; reports pass, fail or timeout through sticky status outputs that the bench turns into $fatal/$finish.

Parameters:
- ADDR_W, 32, instr_address width
- DATA_W, 32, register_v0 / expected value width
- HALT_ADDR, 32'h0000_0000, fetch address that signals program end
- TIMEOUT_CYCLES, 200, enabled cycles allowed in RUN before timeout (≥2)
- CNT_W, 16, cycle counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  system clock (posedge)
  - reset  in  1  synchronous, active-high
- Inputs:
  - clk_enable  in  1  CPU clock enable; monitor advances only when high
  - active  in  1  CPU active flag
  - instr_address  in  ADDR_W  CPU fetch address
  - register_v0  in  DATA_W  CPU $v0 debug output
  - expected_v0  in  DATA_W  golden result, held stable by bench
- Outputs:
  - done  out  1  run finished (any terminal state)
  - pass  out  1  halted and v0 matched
  - fail  out  1  halted and v0 mismatched
  - timed_out  out  1  TIMEOUT_CYCLES elapsed without halt
  - cycle_count  out  CNT_W  enabled cycles spent in RUN
  - final_v0  out  DATA_W  register_v0 captured at check

Behaviour:
- Reset values: state=IDLE; done, pass, fail and timed_out = 0; cycle_count=0; final_v0=0.
- States and transitions (all only on posedge clk with clk_enable=1, except reset):
  - IDLE -> RUN when active=1. cycle_count stays 0.
  - RUN: cycle_count += 1 each enabled cycle.
    - If instr_address==HALT_ADDR -> CHECK.
    - Else if cycle_count==TIMEOUT_CYCLES-1 -> TIMEOUT.
    - Halt has priority over timeout in the same cycle.
  - CHECK: one settle cycle for the final register write-back.
    - Capture final_v0<=register_v0.
    - Go to PASS if register_v0==expected_v0, else FAIL. Comparison is full DATA_W width.
  - PASS / FAIL / TIMEOUT: terminal and sticky until reset.
- Status outputs are registered and asserted from the first cycle in the terminal state:
  - PASS: done=1, pass=1.
  - FAIL: done=1, fail=1.
  - TIMEOUT: done=1, timed_out=1, final_v0=register_v0 at entry.
  - pass, fail and timed_out are mutually exclusive.
- active dropping in RUN before halt is ignored; only halt or timeout ends the run.
- clk_enable=0 freezes state, counters and outputs in every state.
- Reset asserted at any time, including mid-RUN or in a terminal state, returns everything to reset values next edge.
- cycle_count never wraps; it saturates implicitly because TIMEOUT terminates the run first.

Optional Feature:
- Macro: MIPS_RUN_MONITOR_JUMP_TRACE_EN.
- With the macro:
  - Extra output jump_count [CNT_W-1:0], reset 0.
  - In RUN, jump_count increments when instr_address != prev_addr+4, where prev_addr is the previous enabled-cycle fetch address (registered).
  - The first RUN cycle is not counted.
  - Frozen outside RUN.
- Without the macro: the port and logic are absent.

Decomposition:
- Package mips_tb_pkg:
  - typedef enum monitor_state_t {IDLE, RUN, CHECK, PASS, FAIL, TIMEOUT}.
  - localparam RESET_VECTOR=32'hBFC0_0000.
  - Default HALT_ADDR.
- No sub-module; a single FSM plus counters. The optional jump tracker sits inside an ifdef block.

Test Plan:
- Halt with match: active=1, addresses from BFC00000 step +4, address 0 at RUN cycle 10, register_v0=44, expected_v0=44 -> CHECK next, then pass=1, done=1, final_v0=44, cycle_count=10.
- Halt with mismatch: same sequence, register_v0=43, expected 44 -> fail=1, pass=0, final_v0=43.
- Timeout: TIMEOUT_CYCLES=20, address never 0 -> timed_out=1 after cycle_count=20; pass=fail=0.
- Halt and timeout on the same cycle: address 0 exactly on cycle TIMEOUT_CYCLES-1 -> CHECK, not TIMEOUT.
- clk_enable low for 5 cycles mid-RUN, then reset mid-RUN at cycle 7:
  - During the low period: cycle_count is frozen.
  - After reset: all outputs 0, state IDLE; a new run restarts counting from 0.
- Jump trace (macro on): addresses BFC00000, BFC0000C, BFC00010, BFC00018, BFC0001C -> jump_count=2.

Source files
------------

// File: rtl/mips_run_monitor_pkg.sv
// Shared types and constants for the mips_cpu_harvard run monitor.
package mips_tb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    CHECK,
    PASS,
    FAIL,
    TIMEOUT
  } monitor_state_t;

  localparam logic [31:0] RESET_VECTOR      = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR = 32'h0000_0000;

endpackage

// File: rtl/mips_run_monitor_if.sv
// CPU-facing observation bus plus the monitor's sticky status outputs.
// jump_count exists only when MIPS_RUN_MONITOR_JUMP_TRACE_EN is defined.
interface mips_run_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              clk_enable;
  logic              active;
  logic [ADDR_W-1:0] instr_address;
  logic [DATA_W-1:0] register_v0;
  logic [DATA_W-1:0] expected_v0;

  logic              done;
  logic              pass;
  logic              fail;
  logic              timed_out;
  logic [CNT_W-1:0]  cycle_count;
  logic [DATA_W-1:0] final_v0;
`ifdef MIPS_RUN_MONITOR_JUMP_TRACE_EN
  logic [CNT_W-1:0]  jump_count;
`endif

  // master: the bench/CPU side driving observations
  modport master (
    output clk_enable, active, instr_address, register_v0, expected_v0,
`ifdef MIPS_RUN_MONITOR_JUMP_TRACE_EN
    input  jump_count,
`endif
    input  done, pass, fail, timed_out, cycle_count, final_v0
  );

  modport slave (
    input  clk_enable, active, instr_address, register_v0, expected_v0,
`ifdef MIPS_RUN_MONITOR_JUMP_TRACE_EN
    output jump_count,
`endif
    output done, pass, fail, timed_out, cycle_count, final_v0
  );
endinterface

// File: rtl/mips_run_monitor.sv
// End-of-program checker: detects the halt fetch, checks $v0, flags timeouts.
// Optional jump tracing enabled by defining MIPS_RUN_MONITOR_JUMP_TRACE_EN.
module mips_run_monitor
  import mips_tb_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR      = ADDR_W'(DEFAULT_HALT_ADDR),
  parameter int                TIMEOUT_CYCLES = 200,
  parameter int                CNT_W          = 16
) (
  input  logic                clk,
  input  logic                reset,
  mips_run_monitor_if.slave   mon
);

  monitor_state_t    state;
  logic              done_q, pass_q, fail_q, timed_out_q;
  logic [CNT_W-1:0]  cycle_count_q;
  logic [DATA_W-1:0] final_v0_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timed_out_q   <= 1'b0;
      cycle_count_q <= '0;
      final_v0_q    <= '0;
    end else if (mon.clk_enable) begin
      case (state)
        IDLE: if (mon.active) state <= RUN;
        RUN: begin
          cycle_count_q <= cycle_count_q + 1'b1;
          // halt wins over a timeout landing on the same cycle
          if (mon.instr_address == HALT_ADDR) begin
            state <= CHECK;
          end else if (cycle_count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state       <= TIMEOUT;
            done_q      <= 1'b1;
            timed_out_q <= 1'b1;
            final_v0_q  <= mon.register_v0;
          end
        end
        CHECK: begin
          // one settle cycle lets the last write-back reach $v0
          done_q     <= 1'b1;
          final_v0_q <= mon.register_v0;
          if (mon.register_v0 == mon.expected_v0) begin
            state  <= PASS;
            pass_q <= 1'b1;
          end else begin
            state  <= FAIL;
            fail_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mon.done        = done_q;
  assign mon.pass        = pass_q;
  assign mon.fail        = fail_q;
  assign mon.timed_out   = timed_out_q;
  assign mon.cycle_count = cycle_count_q;
  assign mon.final_v0    = final_v0_q;

`ifdef MIPS_RUN_MONITOR_JUMP_TRACE_EN
  logic [ADDR_W-1:0] prev_addr;
  logic              first_run;
  logic [CNT_W-1:0]  jump_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_addr    <= '0;
      first_run    <= 1'b0;
      jump_count_q <= '0;
    end else if (mon.clk_enable) begin
      prev_addr <= mon.instr_address;
      if (state == IDLE && mon.active) first_run <= 1'b1;
      if (state == RUN) begin
        first_run <= 1'b0;
        // the entry cycle has no meaningful predecessor fetch
        if (!first_run && mon.instr_address != prev_addr + ADDR_W'(4))
          jump_count_q <= jump_count_q + 1'b1;
      end
    end
  end

  assign mon.jump_count = jump_count_q;
`endif

endmodule

// File: tb/tb_mips_run_monitor.sv
// Self-checking bench for mips_run_monitor: directed scenarios plus randomized runs
// checked against an outcome model (halt position vs. timeout budget).
module tb_mips_run_monitor;
  import mips_tb_pkg::*;

  localparam int T = 20;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mips_run_monitor_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) mon ();

  mips_run_monitor #(
    .ADDR_W(32), .DATA_W(32), .HALT_ADDR(32'h0), .TIMEOUT_CYCLES(T), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (mon)
  );

  // inputs change just after a negedge; outputs are read at the following negedge
  task automatic drive(input logic en, input logic act, input logic [31:0] addr,
                       input logic [31:0] v0);
    mon.clk_enable    = en;
    mon.active        = act;
    mon.instr_address = addr;
    mon.register_v0   = v0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, RESET_VECTOR, 32'h0);
    reset = 1'b0;
  endtask

  // IDLE cycle then n RUN cycles walking from RESET_VECTOR; address 0 on RUN cycle halt_at
  task automatic run_linear(input int halt_at, input int n, input logic [31:0] v0);
    do_reset();
    drive(1'b1, 1'b1, RESET_VECTOR, v0);
    for (int i = 1; i <= n; i++)
      drive(1'b1, 1'b1, (i == halt_at) ? 32'h0 : RESET_VECTOR + 32'(4 * (i - 1)), v0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mon.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", mon.done); end
    checks++; if (mon.pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", mon.pass); end
    checks++; if (mon.fail !== 1'b0) begin errors++; $display("FAIL reset_fail got %b want 0", mon.fail); end
    checks++; if (mon.timed_out !== 1'b0) begin errors++; $display("FAIL reset_timed_out got %b want 0", mon.timed_out); end
    checks++; if (mon.cycle_count !== 16'd0) begin errors++; $display("FAIL reset_cycle_count got %0d want 0", mon.cycle_count); end
    checks++; if (mon.final_v0 !== 32'd0) begin errors++; $display("FAIL reset_final_v0 got %0h want 0", mon.final_v0); end
  endtask

  task automatic test_halt_match();
    mon.expected_v0 = 32'd44;
    run_linear(10, 10, 32'd44);
    checks++; if (mon.done !== 1'b0) begin errors++; $display("FAIL match_check_done got %b want 0", mon.done); end
    drive(1'b1, 1'b0, 32'h0, 32'd44);
    checks++; if ({mon.done, mon.pass, mon.fail, mon.timed_out} !== 4'b1100)
      begin errors++; $display("FAIL match_flags got %b want 1100", {mon.done, mon.pass, mon.fail, mon.timed_out}); end
    checks++; if (mon.final_v0 !== 32'd44) begin errors++; $display("FAIL match_final_v0 got %0d want 44", mon.final_v0); end
    checks++; if (mon.cycle_count !== 16'd10) begin errors++; $display("FAIL match_cycle_count got %0d want 10", mon.cycle_count); end
    // terminal state is sticky even as inputs keep moving
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 32'h0, 32'd99);
    checks++; if ({mon.done, mon.pass, mon.fail, mon.timed_out} !== 4'b1100 || mon.final_v0 !== 32'd44)
      begin errors++; $display("FAIL sticky_pass got %b/%0d want 1100/44", {mon.done, mon.pass, mon.fail, mon.timed_out}, mon.final_v0); end
    do_reset();
    checks++; if ({mon.done, mon.pass, mon.fail, mon.timed_out} !== 4'b0000 || mon.final_v0 !== 32'd0 || mon.cycle_count !== 16'd0)
      begin errors++; $display("FAIL reset_from_pass got %b/%0d/%0d want 0000/0/0", {mon.done, mon.pass, mon.fail, mon.timed_out}, mon.final_v0, mon.cycle_count); end
  endtask

  task automatic test_halt_mismatch();
    mon.expected_v0 = 32'd44;
    run_linear(10, 10, 32'd43);
    drive(1'b1, 1'b0, 32'h0, 32'd43);
    checks++; if ({mon.done, mon.pass, mon.fail, mon.timed_out} !== 4'b1010)
      begin errors++; $display("FAIL mismatch_flags got %b want 1010", {mon.done, mon.pass, mon.fail, mon.timed_out}); end
    checks++; if (mon.final_v0 !== 32'd43) begin errors++; $display("FAIL mismatch_final_v0 got %0d want 43", mon.final_v0); end
  endtask

  task automatic test_timeout();
    mon.expected_v0 = 32'd1;
    run_linear(0, T - 1, 32'd7);
    checks++; if (mon.done !== 1'b0 || mon.timed_out !== 1'b0)
      begin errors++; $display("FAIL timeout_early got %b%b want 00", mon.done, mon.timed_out); end
    drive(1'b1, 1'b1, 32'hBFC0_1000, 32'd7);
    checks++; if ({mon.done, mon.pass, mon.fail, mon.timed_out} !== 4'b1001)
      begin errors++; $display("FAIL timeout_flags got %b want 1001", {mon.done, mon.pass, mon.fail, mon.timed_out}); end
    checks++; if (mon.cycle_count !== 16'(T)) begin errors++; $display("FAIL timeout_cycle_count got %0d want %0d", mon.cycle_count, T); end
    checks++; if (mon.final_v0 !== 32'd7) begin errors++; $display("FAIL timeout_final_v0 got %0d want 7", mon.final_v0); end
  endtask

  task automatic test_halt_timeout_same();
    mon.expected_v0 = 32'd5;
    run_linear(T, T, 32'd5);
    checks++; if (mon.done !== 1'b0 || mon.timed_out !== 1'b0)
      begin errors++; $display("FAIL same_cycle_check got %b%b want 00", mon.done, mon.timed_out); end
    drive(1'b1, 1'b0, 32'h0, 32'd5);
    checks++; if ({mon.done, mon.pass, mon.fail, mon.timed_out} !== 4'b1100)
      begin errors++; $display("FAIL same_cycle_flags got %b want 1100", {mon.done, mon.pass, mon.fail, mon.timed_out}); end
  endtask

  task automatic test_enable_and_reset();
    mon.expected_v0 = 32'd0;
    run_linear(0, 3, 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 32'h0, 32'd1);
      checks++; if (mon.cycle_count !== 16'd3 || mon.done !== 1'b0)
        begin errors++; $display("FAIL enable_freeze got %0d/%b want 3/0", mon.cycle_count, mon.done); end
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'hBFC0_0100 + 32'(4 * i), 32'd1);
    checks++; if (mon.cycle_count !== 16'd7) begin errors++; $display("FAIL resume_count got %0d want 7", mon.cycle_count); end
    reset = 1'b1;
    drive(1'b1, 1'b1, 32'hBFC0_0200, 32'd1);
    reset = 1'b0;
    checks++; if ({mon.done, mon.pass, mon.fail, mon.timed_out} !== 4'b0000 || mon.cycle_count !== 16'd0 || mon.final_v0 !== 32'd0)
      begin errors++; $display("FAIL midrun_reset got %b/%0d want 0000/0", {mon.done, mon.pass, mon.fail, mon.timed_out}, mon.cycle_count); end
    drive(1'b1, 1'b1, RESET_VECTOR, 32'd1);
    checks++; if (mon.cycle_count !== 16'd0) begin errors++; $display("FAIL idle_count got %0d want 0", mon.cycle_count); end
    drive(1'b1, 1'b1, RESET_VECTOR, 32'd1);
    drive(1'b1, 1'b1, RESET_VECTOR + 32'd4, 32'd1);
    checks++; if (mon.cycle_count !== 16'd2) begin errors++; $display("FAIL restart_count got %0d want 2", mon.cycle_count); end
  endtask

`ifdef MIPS_RUN_MONITOR_JUMP_TRACE_EN
  task automatic test_jump_trace();
    logic [31:0] seq [5];
    seq = '{32'hBFC0_0000, 32'hBFC0_000C, 32'hBFC0_0010, 32'hBFC0_0018, 32'hBFC0_001C};
    do_reset();
    drive(1'b1, 1'b1, RESET_VECTOR, 32'd0);
    foreach (seq[i]) drive(1'b1, 1'b1, seq[i], 32'd0);
    checks++; if (mon.jump_count !== 16'd2) begin errors++; $display("FAIL jump_trace got %0d want 2", mon.jump_count); end
  endtask
`endif

  // Model: a run ends at the earlier of the halt fetch or the T-th enabled RUN cycle.
  task automatic test_random();
    int          halt_at, nrun, njump, exp_cnt;
    bit          halted, ended, en;
    logic [31:0] addr, prev, v0, exp_v0, v_dec;
    for (int it = 0; it < 40; it++) begin
      do_reset();
      halt_at = $urandom_range(1, T + 4);
      exp_v0  = $urandom;
      mon.expected_v0 = exp_v0;
      prev = RESET_VECTOR;
      drive(1'b1, 1'b1, prev, $urandom);
      nrun = 0; njump = 0; ended = 1'b0; v_dec = 32'h0;
      while (!ended) begin
        en = ($urandom_range(0, 3) != 0);
        v0 = ($urandom_range(0, 1) == 1) ? exp_v0 : 32'($urandom);
        if (!en) begin
          drive(1'b0, $urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? 32'h0 : 32'($urandom), v0);
        end else begin
          nrun++;
          if (nrun == halt_at) addr = 32'h0;
          else begin
            addr = ($urandom_range(0, 3) != 0) ? prev + 32'd4 : 32'($urandom);
            if (addr == 32'h0) addr = 32'h4;
          end
          if (nrun > 1 && addr != prev + 32'd4) njump++;
          prev = addr;
          drive(1'b1, (nrun == 1) || ($urandom_range(0, 1) == 1), addr, v0);
          if (nrun == halt_at || nrun == T) begin ended = 1'b1; v_dec = v0; end
        end
      end
      halted  = (halt_at <= T);
      exp_cnt = halted ? halt_at : T;
      if (halted) begin
        for (int k = $urandom_range(0, 2); k > 0; k--) drive(1'b0, 1'b0, 32'($urandom), 32'($urandom));
        v_dec = ($urandom_range(0, 1) == 1) ? exp_v0 : 32'($urandom);
        drive(1'b1, 1'b0, 32'($urandom), v_dec);
      end
      checks++; if (mon.cycle_count !== 16'(exp_cnt))
        begin errors++; $display("FAIL rand_cycle_count it=%0d got %0d want %0d", it, mon.cycle_count, exp_cnt); end
      checks++; if ({mon.done, mon.pass, mon.fail, mon.timed_out} !== {1'b1, halted && v_dec == exp_v0, halted && v_dec != exp_v0, !halted})
        begin errors++; $display("FAIL rand_flags it=%0d got %b want %b", it, {mon.done, mon.pass, mon.fail, mon.timed_out},
          {1'b1, halted && v_dec == exp_v0, halted && v_dec != exp_v0, !halted}); end
      checks++; if (mon.final_v0 !== v_dec)
        begin errors++; $display("FAIL rand_final_v0 it=%0d got %0h want %0h", it, mon.final_v0, v_dec); end
`ifdef MIPS_RUN_MONITOR_JUMP_TRACE_EN
      for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 32'($urandom), 32'($urandom));
      checks++; if (mon.jump_count !== 16'(njump))
        begin errors++; $display("FAIL rand_jump_count it=%0d got %0d want %0d", it, mon.jump_count, njump); end
`endif
    end
  endtask

  initial begin
    mon.clk_enable = 1'b0; mon.active = 1'b0; mon.instr_address = '0;
    mon.register_v0 = '0; mon.expected_v0 = '0;
    @(negedge clk);
    test_reset();
    test_halt_match();
    test_halt_mismatch();
    test_timeout();
    test_halt_timeout_same();
    test_enable_and_reset();
`ifdef MIPS_RUN_MONITOR_JUMP_TRACE_EN
    test_jump_trace();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
